// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: redirect kinds, fetch FSM encoding and default vectors.
package mips_pkg;

    localparam logic [1:0] REDIR_BRANCH = 2'd0;
    localparam logic [1:0] REDIR_JUMP   = 2'd1;
    localparam logic [1:0] REDIR_JREG   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational control-flow target for BRANCH / JUMP / JREG redirects.
module pc_target_calc
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [1:0]        kind_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic [15:0]       branch_imm_i,
    input  logic [25:0]       jump_index_i,
    input  logic [ADDR_W-1:0] jreg_target_i,
    output logic [ADDR_W-1:0] target_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] branch_off;

    // Word offset, sign-extended to the full address width.
    assign branch_off = ADDR_W'($signed({branch_imm_i, 2'b00}));

    always_comb begin
        target_o = '0;
        valid_o  = 1'b1;
        case (kind_i)
            REDIR_BRANCH: target_o = pc_plus4_i + branch_off;
            REDIR_JUMP:   target_o = {pc_plus4_i[ADDR_W-1:28], jump_index_i, 2'b00};
            REDIR_JREG:   target_o = {jreg_target_i[ADDR_W-1:2], 2'b00};
            default:      valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: one outstanding request to variable-latency imem, one-entry decode buffer,
// redirect / exception / interrupt vectoring with a kernel-mode interrupt guard.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(DEF_IRQ_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter int unsigned       IRQ_SYNC  = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_kind,
    input  logic [ADDR_W-1:0] redirect_pc_plus4,
    input  logic [15:0]       branch_imm,
    input  logic [25:0]       jump_index,
    input  logic [ADDR_W-1:0] jreg_target,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_pc_plus4,
    input  logic              irq,
    output logic              irq_ack,
    output logic              epc_valid,
    output logic [ADDR_W-1:0] epc
);

    fetch_state_e        state_q;
    logic [ADDR_W-1:0]   fetch_pc_q;
    logic [ADDR_W-1:0]   if_pc_q;
    logic [ADDR_W-1:0]   if_pc_plus4_q;
    logic [31:0]         if_instr_q;
    logic                stale_q;
    logic                live_q;
    logic [IRQ_SYNC-1:0] irq_sync_q;

    logic [ADDR_W-1:0] redir_target;
    logic              redir_kind_ok;
    logic              redir_present;
    logic              take_exc;
    logic              take_redir;
    logic              take_irq;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic [ADDR_W-1:0] pc_seq;

    pc_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_target (
        .kind_i        (redirect_kind),
        .pc_plus4_i    (redirect_pc_plus4),
        .branch_imm_i  (branch_imm),
        .jump_index_i  (jump_index),
        .jreg_target_i (jreg_target),
        .target_o      (redir_target),
        .valid_o       (redir_kind_ok)
    );

    assign pc_seq = fetch_pc_q + ADDR_W'(4);

    // live_q keeps everything quiet until the first edge after reset release.
    always_comb begin
        redir_present = redirect_valid & redir_kind_ok;
        take_exc      = live_q & exc_req;
        take_redir    = live_q & redir_present & ~exc_req;
        take_irq      = live_q & irq_sync_q[IRQ_SYNC-1] & ~fetch_pc_q[ADDR_W-1]
                        & ~exc_req & ~redir_present;
        flush         = take_exc | take_redir | take_irq;
        new_pc        = fetch_pc_q;
        if (take_exc) begin
            new_pc = EXC_VEC;
        end else if (take_redir) begin
            new_pc = redir_target;
        end else if (take_irq) begin
            new_pc = IRQ_VEC;
        end
    end

    assign imem_req    = live_q & (state_q == ST_IDLE);
    assign imem_addr   = (state_q == ST_IDLE) ? new_pc : fetch_pc_q;
    assign if_valid    = (state_q == ST_HOLD);
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign irq_ack     = take_irq;
    assign epc_valid   = take_exc | take_irq;

    // Interrupt return point is the oldest instruction decode has not yet accepted.
    always_comb begin
        epc = '0;
        if (take_exc) begin
            epc = exc_pc_plus4;
        end else if (take_irq) begin
            epc = (state_q == ST_HOLD) ? if_pc_q : fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_VEC;
            stale_q       <= 1'b0;
            live_q        <= 1'b0;
            irq_sync_q    <= '0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
        end else begin
            live_q     <= 1'b1;
            irq_sync_q <= {irq_sync_q[IRQ_SYNC-2:0], irq};
            fetch_pc_q <= new_pc;
            case (state_q)
                ST_IDLE: begin
                    if (live_q) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        // A response in the same cycle is dropped here; otherwise mark it stale.
                        stale_q <= ~imem_rvalid;
                        if (imem_rvalid) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (imem_rvalid) begin
                        if (stale_q) begin
                            stale_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            if_instr_q    <= imem_rdata;
                            if_pc_q       <= fetch_pc_q;
                            if_pc_plus4_q <= pc_seq;
                            fetch_pc_q    <= pc_seq;
                            state_q       <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (flush || if_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
